// File: rtl/busmux_pkg.sv
// Shared encodings for the datapath bus mux and the control FSM:
// the source index layout and the select classification.
package busmux_pkg;

    typedef enum logic [1:0] {
        SEL_IDLE     = 2'd0,
        SEL_DRIVE    = 2'd1,
        SEL_CONFLICT = 2'd2
    } sel_class_e;

    function automatic int src_idx_w(input int reg_num);
        return $clog2(reg_num + 2);
    endfunction

    // Ri -> i, G -> REG_NUM, DIN -> REG_NUM+1
    function automatic int src_g(input int reg_num);
        return reg_num;
    endfunction

    function automatic int src_din(input int reg_num);
        return reg_num + 1;
    endfunction

endpackage

// File: rtl/busmux_sel_decode.sv
// Classifies the bus select vector {DINout, Gout, Rout} as idle, single driver
// or conflict, and encodes the position of the set bit for the single-driver case.
module busmux_sel_decode
    import busmux_pkg::*;
#(
    parameter int REG_NUM = 8
) (
    input  logic [REG_NUM+1:0]                 sel,
    output sel_class_e                         sel_class,
    output logic [src_idx_w(REG_NUM)-1:0]      idx
);

    localparam int N  = REG_NUM + 2;
    localparam int IW = src_idx_w(REG_NUM);

    logic seen;
    logic many;

    always_comb begin
        seen = 1'b0;
        many = 1'b0;
        idx  = '0;
        for (int i = 0; i < N; i++) begin
            if (sel[i]) begin
                if (seen) many = 1'b1;
                seen = 1'b1;
                idx  = IW'(i);
            end
        end
    end

    always_comb begin
        sel_class = SEL_IDLE;
        if (many)      sel_class = SEL_CONFLICT;
        else if (seen) sel_class = SEL_DRIVE;
    end

endmodule

// File: rtl/busmux_reg.sv
// Registered bus source mux: one-cycle bus register that holds on idle/conflict,
// plus a sticky conflict flag and saturating conflict counter for debug.
module busmux_reg
    import busmux_pkg::*;
#(
    parameter int REG_NUM   = 8,
    parameter int DATAWIDTH = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                              Clock,
    input  logic                              Resetn,
    input  logic [REG_NUM-1:0]                Rout,
    input  logic                              Gout,
    input  logic                              DINout,
    input  logic [REG_NUM*DATAWIDTH-1:0]      R,
    input  logic [DATAWIDTH-1:0]              G,
    input  logic [DATAWIDTH-1:0]              DIN,
    input  logic                              Clear,
    output logic [DATAWIDTH-1:0]              BusWires,
    output logic                              BusValid,
    output logic [src_idx_w(REG_NUM)-1:0]     SrcIdx,
    output logic                              BusErr,
    output logic [CNT_WIDTH-1:0]              ErrCount
);

    localparam int IW = src_idx_w(REG_NUM);

    if (REG_NUM < 2 || REG_NUM > 16) begin : g_bad_reg_num
        $error("busmux_reg: REG_NUM must be in 2..16");
    end

    logic [REG_NUM+1:0]   sel;
    sel_class_e           sel_class;
    logic [IW-1:0]        idx;
    logic [DATAWIDTH-1:0] mux_data;

    assign sel = {DINout, Gout, Rout};

    busmux_sel_decode #(
        .REG_NUM (REG_NUM)
    ) u_decode (
        .sel       (sel),
        .sel_class (sel_class),
        .idx       (idx)
    );

    always_comb begin
        mux_data = DIN;
        for (int i = 0; i < REG_NUM; i++) begin
            if (idx == IW'(i)) mux_data = R[i*DATAWIDTH +: DATAWIDTH];
        end
        if (idx == IW'(src_g(REG_NUM))) mux_data = G;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            BusWires <= '0;
            BusValid <= 1'b0;
            SrcIdx   <= '0;
            BusErr   <= 1'b0;
            ErrCount <= '0;
        end else begin
            BusValid <= (sel_class == SEL_DRIVE);
            if (sel_class == SEL_DRIVE) begin
                BusWires <= mux_data;
                SrcIdx   <= idx;
            end
            // A conflict in the same cycle as Clear counts as the first new conflict.
            if (sel_class == SEL_CONFLICT) begin
                BusErr <= 1'b1;
                if (Clear)
                    ErrCount <= CNT_WIDTH'(1);
                else if (ErrCount != {CNT_WIDTH{1'b1}})
                    ErrCount <= ErrCount + CNT_WIDTH'(1);
            end else if (Clear) begin
                BusErr   <= 1'b0;
                ErrCount <= '0;
            end
        end
    end

endmodule

// File: tb/tb_busmux_reg.sv
// Directed bench for busmux_reg: reset, drives, idle hold, conflicts,
// counter saturation and Clear interaction.
module tb_busmux_reg;

    localparam int REG_NUM = 8;
    localparam int DW      = 16;
    localparam int CW      = 8;

    logic                  Clock;
    logic                  Resetn;
    logic [REG_NUM-1:0]    Rout;
    logic                  Gout;
    logic                  DINout;
    logic [REG_NUM*DW-1:0] R;
    logic [DW-1:0]         G;
    logic [DW-1:0]         DIN;
    logic                  Clear;
    logic [DW-1:0]         BusWires;
    logic                  BusValid;
    logic [3:0]            SrcIdx;
    logic                  BusErr;
    logic [CW-1:0]         ErrCount;

    // {BusWires, BusValid, SrcIdx, BusErr, ErrCount}
    logic [29:0] obs;
    logic [29:0] exp;
    int pass_cnt  = 0;
    int total_cnt = 0;

    busmux_reg #(
        .REG_NUM   (REG_NUM),
        .DATAWIDTH (DW),
        .CNT_WIDTH (CW)
    ) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Rout     (Rout),
        .Gout     (Gout),
        .DINout   (DINout),
        .R        (R),
        .G        (G),
        .DIN      (DIN),
        .Clear    (Clear),
        .BusWires (BusWires),
        .BusValid (BusValid),
        .SrcIdx   (SrcIdx),
        .BusErr   (BusErr),
        .ErrCount (ErrCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    assign obs = {BusWires, BusValid, SrcIdx, BusErr, ErrCount};

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic idle_inputs();
        Rout   = '0;
        Gout   = 1'b0;
        DINout = 1'b0;
        Clear  = 1'b0;
    endtask

    task automatic randomize_inputs();
        Rout   = REG_NUM'($urandom);
        Gout   = 1'($urandom);
        DINout = 1'($urandom);
        Clear  = 1'($urandom);
        R      = {$urandom, $urandom, $urandom, $urandom};
        G      = DW'($urandom);
        DIN    = DW'($urandom);
    endtask

    task automatic test_reset();
        Resetn = 1'b1;
        idle_inputs();
        R = {$urandom, $urandom, $urandom, $urandom};
        G = DW'($urandom);
        DIN = DW'($urandom);
        R[5*DW +: DW] = 16'h5A01;
        Rout = 8'h20;
        tick(1);
        exp = {16'h5A01, 1'b1, 4'd5, 1'b0, 8'd0};
        total_cnt++;
        if (obs[29:9] !== exp[29:9])
            $display("FAIL pre_reset_drive obs=%h exp=%h", obs[29:9], exp[29:9]);
        else pass_cnt++;

        #3;
        Resetn = 1'b0;
        randomize_inputs();
        #1;
        exp = '0;
        total_cnt++;
        if (obs !== exp) $display("FAIL reset_async obs=%h exp=%h", obs, exp);
        else pass_cnt++;

        for (int k = 0; k < 2; k++) begin
            randomize_inputs();
            tick(1);
            total_cnt++;
            if (obs !== exp) $display("FAIL reset_held obs=%h exp=%h", obs, exp);
            else pass_cnt++;
        end

        idle_inputs();
        #2;
        Resetn = 1'b1;
        tick(1);
        total_cnt++;
        if (obs !== exp) $display("FAIL reset_release_idle obs=%h exp=%h", obs, exp);
        else pass_cnt++;
    endtask

    task automatic test_single_reg();
        idle_inputs();
        R[2*DW +: DW] = 16'hA5A5;
        Rout = 8'b0000_0100;
        tick(1);
        exp = {16'hA5A5, 1'b1, 4'd2, 1'b0, 8'd0};
        total_cnt++;
        if (obs !== exp) $display("FAIL single_reg obs=%h exp=%h", obs, exp);
        else pass_cnt++;
    endtask

    task automatic test_g_then_din();
        idle_inputs();
        G = 16'h1234;
        Gout = 1'b1;
        tick(1);
        exp = {16'h1234, 1'b1, 4'd8, 1'b0, 8'd0};
        total_cnt++;
        if (obs !== exp) $display("FAIL g_drive obs=%h exp=%h", obs, exp);
        else pass_cnt++;

        Gout = 1'b0;
        DIN = 16'hBEEF;
        DINout = 1'b1;
        tick(1);
        exp = {16'hBEEF, 1'b1, 4'd9, 1'b0, 8'd0};
        total_cnt++;
        if (obs !== exp) $display("FAIL din_drive obs=%h exp=%h", obs, exp);
        else pass_cnt++;
    endtask

    task automatic test_idle_hold();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            DIN = DW'($urandom);
            G   = DW'($urandom);
            tick(1);
            exp = {16'hBEEF, 1'b0, 4'd9, 1'b0, 8'd0};
            total_cnt++;
            if (obs !== exp) $display("FAIL idle_hold cycle=%0d obs=%h exp=%h", k, obs, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_conflict_saturation();
        idle_inputs();
        Rout = 8'b0000_0011;
        tick(1);
        exp = {16'hBEEF, 1'b0, 4'd9, 1'b1, 8'd1};
        total_cnt++;
        if (obs !== exp) $display("FAIL conflict_first obs=%h exp=%h", obs, exp);
        else pass_cnt++;

        tick(253);
        exp = {16'hBEEF, 1'b0, 4'd9, 1'b1, 8'd254};
        total_cnt++;
        if (obs !== exp) $display("FAIL conflict_254 obs=%h exp=%h", obs, exp);
        else pass_cnt++;

        tick(1);
        exp = {16'hBEEF, 1'b0, 4'd9, 1'b1, 8'd255};
        total_cnt++;
        if (obs !== exp) $display("FAIL conflict_255 obs=%h exp=%h", obs, exp);
        else pass_cnt++;

        tick(45);
        total_cnt++;
        if (obs !== exp) $display("FAIL conflict_saturate obs=%h exp=%h", obs, exp);
        else pass_cnt++;

        R[7*DW +: DW] = 16'h7777;
        Rout = 8'b1000_0000;
        tick(1);
        exp = {16'h7777, 1'b1, 4'd7, 1'b1, 8'd255};
        total_cnt++;
        if (obs !== exp) $display("FAIL sticky_after_drive obs=%h exp=%h", obs, exp);
        else pass_cnt++;
    endtask

    task automatic test_clear();
        idle_inputs();
        Clear = 1'b1;
        tick(1);
        exp = {16'h7777, 1'b0, 4'd7, 1'b0, 8'd0};
        total_cnt++;
        if (obs !== exp) $display("FAIL clear_idle obs=%h exp=%h", obs, exp);
        else pass_cnt++;

        Clear  = 1'b1;
        Gout   = 1'b1;
        DINout = 1'b1;
        tick(1);
        exp = {16'h7777, 1'b0, 4'd7, 1'b1, 8'd1};
        total_cnt++;
        if (obs !== exp) $display("FAIL clear_with_conflict obs=%h exp=%h", obs, exp);
        else pass_cnt++;

        idle_inputs();
        Clear = 1'b1;
        R[0 +: DW] = 16'h0F0F;
        Rout = 8'b0000_0001;
        tick(1);
        exp = {16'h0F0F, 1'b1, 4'd0, 1'b0, 8'd0};
        total_cnt++;
        if (obs !== exp) $display("FAIL clear_with_drive obs=%h exp=%h", obs, exp);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        R[3*DW +: DW] = 16'h3333;
        R[4*DW +: DW] = 16'h4444;
        G = 16'h6666;
        Rout = 8'b0000_1000;
        tick(1);
        exp = {16'h3333, 1'b1, 4'd3, 1'b0, 8'd0};
        total_cnt++;
        if (obs !== exp) $display("FAIL b2b_r3 obs=%h exp=%h", obs, exp);
        else pass_cnt++;

        Rout = 8'b0001_0000;
        tick(1);
        exp = {16'h4444, 1'b1, 4'd4, 1'b0, 8'd0};
        total_cnt++;
        if (obs !== exp) $display("FAIL b2b_r4 obs=%h exp=%h", obs, exp);
        else pass_cnt++;

        Rout = '0;
        Gout = 1'b1;
        tick(1);
        exp = {16'h6666, 1'b1, 4'd8, 1'b0, 8'd0};
        total_cnt++;
        if (obs !== exp) $display("FAIL b2b_g obs=%h exp=%h", obs, exp);
        else pass_cnt++;

        // G plus one register is still a conflict: hold last value
        Rout = 8'b0100_0000;
        tick(1);
        exp = {16'h6666, 1'b0, 4'd8, 1'b1, 8'd1};
        total_cnt++;
        if (obs !== exp) $display("FAIL b2b_g_r6_conflict obs=%h exp=%h", obs, exp);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_reg();
        test_g_then_din();
        test_idle_hold();
        test_conflict_saturation();
        test_clear();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/busmux_reg.md
Name: busmux_reg

Overview:
- Registered, parametrised bus source multiplexer for the multicycle processor datapath.
- Selects one of REG_NUM general registers, the ALU result register G, or external input DIN onto BusWires. The selection comes from the control FSM's one-hot out-enables.
- Adds a one-cycle registered bus, hold-on-idle, multi-driver conflict detection, sticky error flag and saturating conflict counter for debug.

Parameters:
- REG_NUM, 8, number of general registers R0..R(REG_NUM-1); legal range 2..16.
- DATAWIDTH, 16, bus and register data width.
- CNT_WIDTH, 8, width of the conflict counter.

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous active-low reset.
- Rout  in  REG_NUM  one-hot out-enable for R0..R(REG_NUM-1); bit i selects Ri.
- Gout  in  1  out-enable for G.
- DINout  in  1  out-enable for DIN.
- R  in  REG_NUM*DATAWIDTH  flattened register contents; Ri = R[i*DATAWIDTH +: DATAWIDTH].
- G  in  DATAWIDTH  ALU result register.
- DIN  in  DATAWIDTH  external data input.
- Clear  in  1  synchronous clear of BusErr and ErrCount.
- BusWires  out  DATAWIDTH  registered bus value.
- BusValid  out  1  high for one cycle after a cycle with exactly one legal driver.
- SrcIdx  out  $clog2(REG_NUM+2)  encoded source of the current BusWires value.
- BusErr  out  1  sticky multi-driver conflict flag.
- ErrCount  out  CNT_WIDTH  saturating count of conflict cycles.

Behaviour:
- Reset: Resetn low asynchronously forces all outputs to 0 immediately (BusWires, BusValid, SrcIdx, BusErr, ErrCount), independent of Clock. Deassertion is synchronised externally.
- Select vector Sel = {DINout, Gout, Rout}, REG_NUM+2 bits. It is sampled on each rising Clock edge.
- Popcount(Sel)==1 (drive):
  - BusWires <= selected source; BusValid <= 1.
  - SrcIdx <= i for Ri, REG_NUM for G, REG_NUM+1 for DIN.
  - Latency is one cycle: the value captured at edge n is visible after edge n.
- Popcount(Sel)==0 (idle):
  - BusWires and SrcIdx hold; BusValid <= 0.
  - No default-to-DIN fallthrough.
- Popcount(Sel)>=2 (conflict):
  - BusWires and SrcIdx hold; BusValid <= 0.
  - BusErr <= 1.
  - ErrCount <= ErrCount+1, saturating at 2^CNT_WIDTH-1 (no wrap).
- BusErr stays 1 until Clear or reset; later legal cycles do not clear it.
- Clear (sampled on the edge): BusErr <= 0, ErrCount <= 0.
  - Simultaneous Clear and conflict: conflict wins; BusErr=1, ErrCount=1.
  - Clear does not affect BusWires, SrcIdx or BusValid.
  - A drive cycle proceeds normally alongside Clear.
- Source data (R, G, DIN) is sampled at the same edge as Sel. There is no internal pipelining of data versus select.
- BusValid is a level for consecutive drive cycles: it stays high continuously while each cycle has exactly one driver.
- No X-propagation: every output is assigned in every branch.

Decomposition:
- Shared package busmux_pkg holds:
  - function src_idx_w(REG_NUM) = $clog2(REG_NUM+2);
  - functions src_g(REG_NUM) = REG_NUM and src_din(REG_NUM) = REG_NUM+1 (source index encoding);
  - a typedef enum for the sel classification {SEL_IDLE, SEL_DRIVE, SEL_CONFLICT}.
  - The control FSM imports the same package, so both blocks use one encoding.
- One combinational sub-module, busmux_sel_decode, with:
  - input Sel (REG_NUM+2 bits);
  - outputs: the classification (zero/one/many) and the encoded index of the single set bit.
- The top busmux_reg instantiates busmux_sel_decode and holds all registers plus the data mux indexed by the encoded index.

Test Plan:
- Reset: REG_NUM=8, DATAWIDTH=16, all inputs random, Resetn=0 mid-cycle -> all outputs 0 before the next edge; they stay 0 until Resetn=1 and a drive cycle occurs.
- Single register drive: Rout=8'b0000_0100, R2=16'hA5A5 -> after the edge: BusWires=16'hA5A5, BusValid=1, SrcIdx=2.
- G then DIN: Gout=1, G=16'h1234 -> BusWires=16'h1234, SrcIdx=8. Next cycle DINout=1, DIN=16'hBEEF -> BusWires=16'hBEEF, SrcIdx=9, BusValid high both cycles.
- Idle hold: after the previous step, all selects 0 for 3 cycles -> BusWires=16'hBEEF, SrcIdx=9, BusValid=0, BusErr=0.
- Conflict and saturation:
  - Rout=8'b0000_0011 for 1 cycle -> BusWires held, BusValid=0, BusErr=1, ErrCount=1.
  - Hold the conflict 300 cycles -> ErrCount=255, no wrap.
  - Then Rout=8'b1000_0000 -> BusErr remains 1.
- Clear interaction:
  - Clear=1 with idle selects -> BusErr=0, ErrCount=0.
  - Clear=1 together with Gout=1 and DINout=1 -> BusErr=1, ErrCount=1, BusWires unchanged.
